// File: rtl/ctr_drbg_temp_gen_if.sv
// ---------------------------------------------------------------------------
// ctr_drbg_temp_gen_if
// Bundles the command, result and external AES-core handshake signals of
// ctr_drbg_temp_gen.
//   slave  : the temp generator itself
//   master : the surrounding logic (command issuer + AES-256 core)
// Signals:
//   start, key_in[255:0], v_in[127:0], provided_data[383:0]  command
//   aes_req, aes_key[255:0], aes_block[127:0]                 AES request
//   aes_ack, aes_result[127:0]                                AES response
//   data_out[383:0], done, busy                               result/status
// ---------------------------------------------------------------------------
interface ctr_drbg_temp_gen_if;
   logic         start;
   logic [255:0] key_in;
   logic [127:0] v_in;
   logic [383:0] provided_data;
   logic         aes_req;
   logic [255:0] aes_key;
   logic [127:0] aes_block;
   logic         aes_ack;
   logic [127:0] aes_result;
   logic [383:0] data_out;
   logic         done;
   logic         busy;

   modport master (
      output start, key_in, v_in, provided_data, aes_ack, aes_result,
      input  aes_req, aes_key, aes_block, data_out, done, busy
   );

   modport slave (
      input  start, key_in, v_in, provided_data, aes_ack, aes_result,
      output aes_req, aes_key, aes_block, data_out, done, busy
   );
endinterface

// File: rtl/ctr_drbg_temp_gen.sv
// ---------------------------------------------------------------------------
// ctr_drbg_temp_gen
// Computes temp = AES_K(V+1) || AES_K(V+2) || AES_K(V+3) XOR provided_data
// for the CTR_DRBG update stage, using a shared external AES-256 core via a
// level req / one-cycle ack handshake.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   io_bus  slave side of ctr_drbg_temp_gen_if (command, AES handshake,
//           data_out/done/busy)
// ---------------------------------------------------------------------------
module ctr_drbg_temp_gen (
   input logic                  clk,
   input logic                  rst_n,
   ctr_drbg_temp_gen_if.slave   io_bus
);

   typedef enum logic [1:0] {StIdle, StInc, StReq, StDone} state_e;

   state_e       r_state;
   logic [255:0] r_key;
   logic [127:0] r_v;
   logic [383:0] r_mask;
   logic [383:0] r_temp;
   logic [1:0]   r_blk_cnt;
   logic         r_req;
   logic [127:0] r_block;
   logic [383:0] r_data_out;
   logic         r_done;
   logic         r_busy;

   logic [127:0] w_v_next;
   logic [383:0] w_temp_final;

   assign w_v_next     = r_v + 128'd1;
   // The last slot is folded in straight from the ack cycle so data_out can
   // update on the same edge that enters DONE.
   assign w_temp_final = {r_temp[383:128], io_bus.aes_result};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_key      <= '0;
         r_v        <= '0;
         r_mask     <= '0;
         r_temp     <= '0;
         r_blk_cnt  <= '0;
         r_req      <= 1'b0;
         r_block    <= '0;
         r_data_out <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_bus.start) begin
                  r_key     <= io_bus.key_in;
                  r_v       <= io_bus.v_in;
                  r_mask    <= io_bus.provided_data;
                  r_blk_cnt <= 2'd0;
                  r_busy    <= 1'b1;
                  r_state   <= StInc;
               end
            end
            StInc: begin
               r_v     <= w_v_next;
               r_block <= w_v_next;
               r_req   <= 1'b1;
               r_state <= StReq;
            end
            StReq: begin
               if (io_bus.aes_ack) begin
                  r_req <= 1'b0;
                  case (r_blk_cnt)
                     2'd0:    r_temp[383:256] <= io_bus.aes_result;
                     2'd1:    r_temp[255:128] <= io_bus.aes_result;
                     default: r_temp[127:0]   <= io_bus.aes_result;
                  endcase
                  if (r_blk_cnt == 2'd2) begin
                     r_data_out <= w_temp_final ^ r_mask;
                     r_done     <= 1'b1;
                     r_state    <= StDone;
                  end else begin
                     r_blk_cnt <= r_blk_cnt + 2'd1;
                     r_state   <= StInc;
                  end
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.aes_req   = r_req;
   assign io_bus.aes_key   = r_key;
   assign io_bus.aes_block = r_block;
   assign io_bus.data_out  = r_data_out;
   assign io_bus.done      = r_done;
   assign io_bus.busy      = r_busy;

endmodule
